axi_lite_mem_slave: RTL
=======================

Name: axi_lite_mem_slave

Overview:
Parametrised AXI4-Lite slave memory for the PicoRV32 AXI SoC. It replaces hand-driven mem_axi_* response stimulus with a real word-addressed RAM. Read and write latencies are programmable, accesses outside the array get SLVERR, and backpressure injection is optional. It sits on the CPU memory port in soc_top and is reused in benches.

Parameters:
DATA_W, 32, data width; 32 or 64 only.
ADDR_W, 32, address width.
DEPTH_WORDS, 1024, number of DATA_W words; any value ≥1.
RD_LATENCY, 1, cycles from AR handshake to rvalid; must be ≥1.
WR_LATENCY, 0, extra cycles between write commit and bvalid; ≥0.
ERR_RDATA, 32'hDEADBEEF, read data returned on SLVERR, replicated to DATA_W.
LFSR_SEED, 16'hACE1, stall-LFSR seed; nonzero; used only with the optional feature.

Ports:
clk  in  1  system clock, all logic on the rising edge.
resetn  in  1  asynchronous, active-low reset.
s_awvalid / s_awready  in / out  1  write-address handshake.
s_awaddr  in  ADDR_W  write byte address.
s_awprot  in  3  ignored.
s_wvalid / s_wready  in / out  1  write-data handshake.
s_wdata  in  DATA_W  write data.
s_wstrb  in  DATA_W/8  byte enables.
s_bvalid / s_bready  out / in  1  write-response handshake.
s_bresp  out  2  OKAY=00, SLVERR=10.
s_arvalid / s_arready  in / out  1  read-address handshake.
s_araddr  in  ADDR_W  read byte address.
s_arprot  in  3  ignored.
s_rvalid / s_rready  out / in  1  read-data handshake.
s_rdata  out  DATA_W  read data.
s_rresp  out  2  OKAY / SLVERR.

Behaviour:
- Interface: single clock clk; reset resetn is asynchronous, active-low.
- Reset values: all readies 0, bvalid 0, rvalid 0, rdata 0, bresp 00, rresp 00. The first cycle after reset release keeps the readies at 0 (registered alive flag). RAM contents are not reset.
- Addressing: word index = addr >> log2(DATA_W/8); low byte-offset bits are ignored. An index ≥ DEPTH_WORDS is out of range.
- Write FSM states: W_IDLE, W_LAT, W_RESP.
  - W_IDLE: awready and wready are independent. Each handshake latches its channel and drops that ready until both are held. AW-first, W-first and simultaneous arrival are all legal.
  - Commit: on the cycle both are held, the RAM is written per wstrb bytes, unless out of range (dropped). Then go to W_LAT if WR_LATENCY>0, else W_RESP.
  - W_LAT: counts WR_LATENCY cycles, then W_RESP.
  - W_RESP: bvalid=1 with bresp; hold bvalid and bresp stable until bready. On the bvalid&&bready cycle return to W_IDLE, readies reassert the next cycle.
  - Only one write is outstanding.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: arready=1; the handshake latches the address and goes to R_WAIT.
  - R_WAIT: counts RD_LATENCY-1 cycles. The RAM is sampled on entry to R_DATA. With RD_LATENCY=1, rvalid asserts on the cycle after the handshake.
  - R_DATA: rvalid=1; hold rdata and rresp stable until rready. Out-of-range reads return ERR_RDATA with SLVERR.
  - Only one read is outstanding.
- Same-cycle hazard: a write commit and a read sample of the same word in one cycle → the read returns the pre-write data.
- Concurrency: the read and write FSMs are fully independent and may run concurrently.
- Reset mid-transaction: both FSMs return to IDLE immediately and held requests are discarded. Any commit completed before reset stays in RAM.

Optional Feature:
AXI_MEM_STALL_INJECT_EN:
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed LFSR_SEED) advances every cycle. When its bit0=1, awready, wready and arready are forced 0 that cycle. The LFSR resets to LFSR_SEED. Valid/response channels are unaffected.
- Undefined: readies follow the FSM only; no LFSR logic is present.

Decomposition:
Package axi_lite_mem_pkg holds:
- RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
- the write-state enum (W_IDLE/W_LAT/W_RESP);
- the read-state enum (R_IDLE/R_WAIT/R_DATA);
- the LFSR tap constant.
Sub-module axi_stall_lfsr (16-bit LFSR, enable/seed) is instantiated only under AXI_MEM_STALL_INJECT_EN.

Test Plan:
1. Write 32'h12345678 to 0x10 with strb 1111, then read 0x10 → bresp 00, rdata 32'h12345678 and rresp 00; rvalid exactly RD_LATENCY cycles after the AR handshake.
2. Write 32'hAABBCCDD strb 0101 over 32'h11111111 at 0x20, read back → 32'h11BB11DD.
3. W presented 3 cycles before AW at 0x8, bready held low 5 cycles → bvalid held stable the whole time, single commit, bvalid drops the cycle after bready.
4. Read/write at address DEPTH_WORDS*4 → bresp 10 with RAM unchanged; rdata 32'hDEADBEEF with rresp 10.
5. RD_LATENCY=4, WR_LATENCY=2; same-cycle commit and read sample of 0x30 → read returns old value; bvalid appears 3 cycles after the commit.
6. resetn pulled low during R_WAIT and W_LAT → rvalid and bvalid 0 immediately; readies 0 for one cycle after release, then 1; the previously committed word still reads back.

Source files
------------

// File: rtl/axi_lite_mem_pkg.sv
// Shared constants and state types for the AXI4-Lite memory slave.
// Used by axi_lite_mem_slave and axi_stall_lfsr.
package axi_lite_mem_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    localparam int unsigned LAT_CNT_W   = 16;

    typedef enum logic [1:0] {
        W_IDLE,
        W_LAT,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between a master (CPU or bench) and axi_lite_mem_slave.
interface axi_lite_mem_slave_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  s_awvalid;
    logic                  s_awready;
    logic [ADDR_W-1:0]     s_awaddr;
    logic [2:0]            s_awprot;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [DATA_W-1:0]     s_wdata;
    logic [DATA_W/8-1:0]   s_wstrb;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [1:0]            s_bresp;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [ADDR_W-1:0]     s_araddr;
    logic [2:0]            s_arprot;
    logic                  s_rvalid;
    logic                  s_rready;
    logic [DATA_W-1:0]     s_rdata;
    logic [1:0]            s_rresp;

    modport master (
        output s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_arprot, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
    );

    modport slave (
        input  s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_arprot, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
    );

endinterface

// File: rtl/axi_stall_lfsr.sv
// 16-bit Fibonacci LFSR used to inject pseudo-random ready stalls.
module axi_stall_lfsr
    import axi_lite_mem_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// Word-addressed AXI4-Lite RAM slave with programmable read/write latency and SLVERR on
// out-of-range accesses. Define AXI_MEM_STALL_INJECT_EN to add LFSR-driven ready stalls.
//
// state  | meaning
// W_IDLE | collecting AW and W independently; commit once both are held
// W_LAT  | counting WR_LATENCY cycles after the commit
// W_RESP | bvalid asserted, waiting for bready
// R_IDLE | arready asserted, waiting for an address
// R_WAIT | counting RD_LATENCY-1 cycles before sampling the RAM
// R_DATA | rvalid asserted, waiting for rready
module axi_lite_mem_slave
    import axi_lite_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned WR_LATENCY  = 0,
    parameter logic [31:0] ERR_RDATA   = 32'hDEADBEEF,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 resetn,
    axi_lite_mem_slave_if.slave  s
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;
    localparam int unsigned MEM_AW = clog2_min1(DEPTH_WORDS);
    localparam logic [DATA_W-1:0] ERR_WORD = {(DATA_W/32){ERR_RDATA}};

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(DEPTH_WORDS);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic alive_q;
    logic stall;

    logic awready, wready, arready;
    logic commit;

    w_state_e              w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [IDX_W-1:0]      widx_q, widx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [LAT_CNT_W-1:0]  wlat_q, wlat_d;
    logic [1:0]            bresp_q, bresp_d;

    r_state_e              r_state_q, r_state_d;
    logic [IDX_W-1:0]      ridx_q, ridx_d;
    logic [LAT_CNT_W-1:0]  rlat_q, rlat_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  sample;
    logic [IDX_W-1:0]      sample_idx;

`ifdef AXI_MEM_STALL_INJECT_EN
    logic [15:0] lfsr;

    axi_stall_lfsr #(.SEED(LFSR_SEED)) u_stall_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (1'b1),
        .lfsr_o (lfsr)
    );

    assign stall = lfsr[0];

    logic unused_lfsr;
    assign unused_lfsr = ^lfsr[15:1];
`else
    assign stall = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{s.s_awprot, s.s_arprot, s.s_awaddr[OFF_W-1:0], s.s_araddr[OFF_W-1:0]};

    // Write channel
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wlat_d    = wlat_q;
        bresp_d   = bresp_q;
        awready   = 1'b0;
        wready    = 1'b0;
        commit    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready = alive_q && !aw_held_q && !stall;
                wready  = alive_q && !w_held_q && !stall;
                if (s.s_awvalid && awready) begin
                    aw_held_d = 1'b1;
                    widx_d    = s.s_awaddr[ADDR_W-1:OFF_W];
                end
                if (s.s_wvalid && wready) begin
                    w_held_d = 1'b1;
                    wdata_d  = s.s_wdata;
                    wstrb_d  = s.s_wstrb;
                end
                if (aw_held_q && w_held_q) begin
                    commit    = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bresp_d   = idx_ok(widx_q) ? RESP_OKAY : RESP_SLVERR;
                    if (WR_LATENCY > 0) begin
                        w_state_d = W_LAT;
                        wlat_d    = LAT_CNT_W'(WR_LATENCY - 1);
                    end else begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_LAT: begin
                if (wlat_q == '0) begin
                    w_state_d = W_RESP;
                end else begin
                    wlat_d = wlat_q - LAT_CNT_W'(1);
                end
            end
            W_RESP: begin
                if (s.s_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel; RAM is sampled on the transition into R_DATA
    always_comb begin
        r_state_d  = r_state_q;
        ridx_d     = ridx_q;
        rlat_d     = rlat_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        arready    = 1'b0;
        sample     = 1'b0;
        sample_idx = ridx_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready = alive_q && !stall;
                if (s.s_arvalid && arready) begin
                    ridx_d = s.s_araddr[ADDR_W-1:OFF_W];
                    if (RD_LATENCY > 1) begin
                        r_state_d = R_WAIT;
                        rlat_d    = LAT_CNT_W'(RD_LATENCY - 2);
                    end else begin
                        r_state_d  = R_DATA;
                        sample     = 1'b1;
                        sample_idx = s.s_araddr[ADDR_W-1:OFF_W];
                    end
                end
            end
            R_WAIT: begin
                if (rlat_q == '0) begin
                    r_state_d = R_DATA;
                    sample    = 1'b1;
                end else begin
                    rlat_d = rlat_q - LAT_CNT_W'(1);
                end
            end
            R_DATA: begin
                if (s.s_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (sample) begin
            if (idx_ok(sample_idx)) begin
                rdata_d = mem_q[sample_idx[MEM_AW-1:0]];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = ERR_WORD;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alive_q   <= 1'b0;
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            widx_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wlat_q    <= '0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            ridx_q    <= '0;
            rlat_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            alive_q   <= 1'b1;
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wlat_q    <= wlat_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            ridx_q    <= ridx_d;
            rlat_q    <= rlat_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // RAM has no reset; out-of-range commits are dropped
    always_ff @(posedge clk) begin
        if (commit && idx_ok(widx_q)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) begin
                    mem_q[widx_q[MEM_AW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign s.s_awready = awready;
    assign s.s_wready  = wready;
    assign s.s_bvalid  = (w_state_q == W_RESP);
    assign s.s_bresp   = bresp_q;
    assign s.s_arready = arready;
    assign s.s_rvalid  = (r_state_q == R_DATA);
    assign s.s_rdata   = rdata_q;
    assign s.s_rresp   = rresp_q;

endmodule
